// File: rtl/sub_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : sub_serial_if
//  Description : Operand/result bundle for the bit-serial subtractor.
//                master = requester (drives start/a/b), slave = subtractor.
//                The ovf signal exists only when SUB_SERIAL_OVF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface sub_serial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic             borrow;
    logic             busy;
    logic             done;
    logic [4:7]       led;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf;

    modport master (output start, a, b,
                    input  q, borrow, busy, done, led, ovf);
    modport slave  (input  start, a, b,
                    output q, borrow, busy, done, led, ovf);
`else
    modport master (output start, a, b,
                    input  q, borrow, busy, done, led);
    modport slave  (input  start, a, b,
                    output q, borrow, busy, done, led);
`endif
endinterface
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
//  Module      : sub_serial
//  Description : Bit-serial WIDTH-bit subtractor, q = a - b, LSB first, one
//                full-subtractor stage with a registered borrow. Result and
//                borrow hold until the next completion; low nibble of q is
//                mirrored on an active-low LED bank.
//                Optional feature macro: SUB_SERIAL_OVF_EN (signed overflow).
//  Revision    : 1.0  initial release
// ============================================================================
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  wire          clk,
    input  wire          rst_n,
    sub_serial_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [WIDTH-1:0]   r_ar;
    logic [WIDTH-1:0]   r_br;
    logic [WIDTH-1:0]   r_dr;
    logic               r_bw;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_q;
    logic               r_borrow;
    logic [4:7]         r_led;

    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_bw_nxt;
    logic [WIDTH-1:0]   w_dr_nxt;
    logic [4:7]         w_led_nxt;

`ifdef SUB_SERIAL_OVF_EN
    logic               r_amsb;
    logic               r_bmsb;
    logic               r_ovf;
    logic               w_ovf_nxt;
`endif

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_last   = (r_cnt == c_LAST);

    // State register together with the registered busy/done flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state decode; busy/done are the flags of the state being entered
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One full-subtractor bit plus the result/LED image it would complete
    always_comb begin
        w_d      = r_ar[0] ^ r_br[0] ^ r_bw;
        w_bw_nxt = (~r_ar[0] & r_br[0]) | (~(r_ar[0] ^ r_br[0]) & r_bw);
        w_dr_nxt = {w_d, r_dr[WIDTH-1:1]};
        w_led_nxt = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            w_led_nxt[4+i] = ~w_dr_nxt[i];
        end
`ifdef SUB_SERIAL_OVF_EN
        // Operand signs differ and the result sign departs from the minuend
        w_ovf_nxt = (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
`endif
    end

    // Operand latch, serial shift and result capture on the last bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ar     <= '0;
            r_br     <= '0;
            r_dr     <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_borrow <= 1'b0;
            r_led    <= 4'b1111;
`ifdef SUB_SERIAL_OVF_EN
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_ar     <= bus.a;
            r_br     <= bus.b;
            r_dr     <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
`ifdef SUB_SERIAL_OVF_EN
            r_amsb   <= bus.a[WIDTH-1];
            r_bmsb   <= bus.b[WIDTH-1];
`endif
        end else if (r_state == ST_RUN) begin
            r_ar     <= {1'b0, r_ar[WIDTH-1:1]};
            r_br     <= {1'b0, r_br[WIDTH-1:1]};
            r_dr     <= w_dr_nxt;
            r_bw     <= w_bw_nxt;
            r_cnt    <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_q      <= w_dr_nxt;
                r_borrow <= w_bw_nxt;
                r_led    <= w_led_nxt;
`ifdef SUB_SERIAL_OVF_EN
                r_ovf    <= w_ovf_nxt;
`endif
            end
        end
    end

    assign bus.q      = r_q;
    assign bus.borrow = r_borrow;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.led    = r_led;
`ifdef SUB_SERIAL_OVF_EN
    assign bus.ovf    = r_ovf;
`endif

endmodule
`default_nettype wire
